// File: rtl/key_debounce.sv
// key_debounce: pushbutton front end.
// Two-flop synchronizer, stability-count debounce FSM, and registered
// clean level plus single-cycle press/release pulses.
// Optional: define KEY_DEBOUNCE_BOUNCE_CNT_EN to add the 8-bit saturating
// bounce_count port, which counts aborted debounce attempts.
module key_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  output logic       key_clean,
  output logic       press_pulse,
  output logic       release_pulse
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
  ,
  output logic [7:0] bounce_count
`endif
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST     = CW'(STABLE_CYCLES - 1);
  localparam logic          RELEASED = ACTIVE_LOW;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    CHK_DN = 2'd1,
    DOWN   = 2'd2,
    CHK_UP = 2'd3
  } state_t;

  logic          sync1;
  logic          sync2;
  logic          pressed_s;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clean_nxt;
  logic          press_nxt;
  logic          release_nxt;

  // Bring the asynchronous pin into the clk domain; idle at the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Normalise polarity so the FSM always sees 1 = pressed.
  assign pressed_s = sync2 ^ ACTIVE_LOW;

  // State and stability counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts from zero on every transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      UP: begin
        if (pressed_s) begin
          state_nxt = CHK_DN;
          cnt_nxt   = '0;
        end
      end
      CHK_DN: begin
        if (!pressed_s) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DOWN: begin
        if (!pressed_s) begin
          state_nxt = CHK_UP;
          cnt_nxt   = '0;
        end
      end
      CHK_UP: begin
        if (pressed_s) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = UP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they land on the same edge
  // as the accepting transition rather than one cycle later.
  always_comb begin
    clean_nxt   = (state_nxt == DOWN) || (state_nxt == CHK_UP);
    press_nxt   = (state == CHK_DN) && (state_nxt == DOWN);
    release_nxt = (state == CHK_UP) && (state_nxt == UP);
  end

  // Registered outputs; reset forces them low without producing a release pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_clean     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      key_clean     <= clean_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
  logic abort;

  assign abort = ((state == CHK_DN) && !pressed_s) ||
                 ((state == CHK_UP) &&  pressed_s);

  // Count aborted debounce attempts, holding at full scale.
  always_ff @(posedge clk) begin
    if (reset) begin
      bounce_count <= 8'd0;
    end else if (abort && (bounce_count != 8'hFF)) begin
      bounce_count <= bounce_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed plus randomized bench for key_debounce.
// Two instances: (STABLE_CYCLES=4, ACTIVE_LOW=1) and (STABLE_CYCLES=1, ACTIVE_LOW=0),
// both driven from the same key_raw and checked against a run-length model.
module tb_key_debounce;

  logic clk = 1'b0;
  logic reset;
  logic key_raw;

  logic kc0, pp0, rp0;
  logic kc1, pp1, rp1;
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
  logic [7:0] bc0, bc1;
`endif

  always #5 clk = ~clk;

  key_debounce #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut0 (
    .clk           (clk),
    .reset         (reset),
    .key_raw       (key_raw),
    .key_clean     (kc0),
    .press_pulse   (pp0),
    .release_pulse (rp0)
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
    ,
    .bounce_count  (bc0)
`endif
  );

  key_debounce #(.STABLE_CYCLES(1), .ACTIVE_LOW(1'b0)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .key_raw       (key_raw),
    .key_clean     (kc1),
    .press_pulse   (pp1),
    .release_pulse (rp1)
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
    ,
    .bounce_count  (bc1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the pressed level seen by the debouncer is the pin delayed
  // by two clocks; a new level is accepted once it has been seen on
  // STABLE_CYCLES+1 consecutive edges, and any run broken early is one bounce.
  int m_stable[2] = '{4, 1};
  int m_al[2]     = '{1, 0};
  int m_s1[2];
  int m_s2[2];
  int m_lvl[2];
  int m_run[2];
  int m_pp[2];
  int m_rp[2];
  int m_bc[2];

  int pat[8] = '{0, 0, 1, 0, 0, 1, 1, 1};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int i);
    int p;
    if (reset) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      m_pp[i] = 0; m_rp[i] = 0; m_bc[i] = 0;
    end else begin
      p       = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = (m_al[i] != 0) ? (key_raw ? 0 : 1) : (key_raw ? 1 : 0);
      m_pp[i] = 0;
      m_rp[i] = 0;
      if (p != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == m_stable[i] + 1) begin
          m_lvl[i] = p;
          m_run[i] = 0;
          if (p != 0) m_pp[i] = 1; else m_rp[i] = 1;
        end
      end else begin
        if (m_run[i] > 0 && m_bc[i] < 255) m_bc[i]++;
        m_run[i] = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("model_kc0", kc0, m_lvl[0]);
    check("model_pp0", pp0, m_pp[0]);
    check("model_rp0", rp0, m_rp[0]);
    check("model_kc1", kc1, m_lvl[1]);
    check("model_pp1", pp1, m_pp[1]);
    check("model_rp1", rp1, m_rp[1]);
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
    check("model_bc0", bc0, m_bc[0]);
    check("model_bc1", bc1, m_bc[1]);
`endif
  endtask

  // One clock: drive on the falling edge, advance the model on the rising
  // edge, sample 1 time unit later.
  task automatic step(input logic raw, input logic rst);
    @(negedge clk);
    key_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_model();
  endtask

  initial begin
    int v;
    int len;
    reset   = 1'b1;
    key_raw = 1'b1;

    // Reset with the key released, then idle.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst_kc", kc0, 0);
    check("rst_pp", pp0, 0);
    check("rst_rp", rp0, 0);
    for (int e = 0; e < 20; e++) begin
      step(1'b1, 1'b0);
      check("idle_kc", kc0, 0);
      check("idle_pulse", pp0 | rp0, 0);
    end

    // Clean press: accepted on the 7th edge.
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      check("press_kc", kc0, (e >= 7) ? 1 : 0);
      check("press_pp", pp0, (e == 7) ? 1 : 0);
    end
    repeat (4) step(1'b0, 1'b0);

    // Clean release.
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 1'b0);
      check("release_kc", kc0, (e >= 7) ? 0 : 1);
      check("release_rp", rp0, (e == 7) ? 1 : 0);
    end
    repeat (4) step(1'b1, 1'b0);

    // Bouncy press: two aborted attempts, then a stable low.
    for (int k = 0; k < 8; k++) begin
      step(pat[k] != 0, 1'b0);
      check("bounce_pp_early", pp0, 0);
      check("bounce_kc_early", kc0, 0);
    end
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      check("bounce_pp", pp0, (e == 7) ? 1 : 0);
    end
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
    check("bounce_cnt2", bc0, 2);
`endif
    repeat (10) step(1'b1, 1'b0);

    // Reset while in CHK_DN with cnt=2.
    repeat (5) step(1'b0, 1'b0);
    check("chk_kc", kc0, 0);
    step(1'b0, 1'b1);
    check("midrst_kc0", kc0, 0);
    check("midrst_pp0", pp0, 0);
    check("midrst_rp0", rp0, 0);
    check("midrst_out1", {kc1, pp1, rp1}, 0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      check("postrst_pp", pp0, (e == 7) ? 1 : 0);
    end

    // Reset while pressed: no release pulse, ever.
    step(1'b0, 1'b1);
    check("downrst_kc", kc0, 0);
    check("downrst_rp", rp0, 0);
    step(1'b1, 1'b1);
    for (int e = 0; e < 10; e++) begin
      step(1'b1, 1'b0);
      check("downrst_quiet", {kc0, pp0, rp0}, 0);
    end

    // Randomized bouncing with occasional resets.
    for (int n = 0; n < 150; n++) begin
      v   = $urandom_range(0, 1);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) step(v != 0, 1'b0);
      if ($urandom_range(0, 39) == 0) step(v != 0, 1'b1);
    end

    // Many short glitches from released: never accepted, count saturates.
    repeat (10) step(1'b1, 1'b0);
    for (int n = 0; n < 300; n++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      check("glitch_kc", kc0, 0);
    end
`ifdef KEY_DEBOUNCE_BOUNCE_CNT_EN
    check("glitch_sat", bc0, 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
